// File: rtl/matrix_fetch_seq.sv
// Matrix operand fetch sequencer: steps an external counter_2d and turns each (row,col)
// into a registered memory read request, forming base + row*stride + col by accumulation.
module matrix_fetch_seq #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST_L,
    input  logic              VDD,
    input  logic              GND,
    input  logic              start,
    input  logic [9:0]        cfg_row_max,
    input  logic [9:0]        cfg_col_max,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    output logic [9:0]        row_max,
    output logic [9:0]        col_max,
    input  logic [9:0]        row,
    input  logic [9:0]        col,
    output logic              inc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [9:0]        req_row,
    output logic [9:0]        req_col,
    output logic              req_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_slot_free;
    logic              w_row_end;
    logic              w_pass_end;
    logic              w_cfg_load;
    logic              w_load;
    logic              w_drain_acc;
    logic              w_unused_pwr;

    logic [9:0]        r_row_max;
    logic [9:0]        r_col_max;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [9:0]        r_req_row;
    logic [9:0]        r_req_col;
    logic              r_req_last;
    logic              r_busy;
    logic              r_done;

    // Supply pins are present for netlist compatibility only.
    assign w_unused_pwr = ^{VDD, GND};

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_load  = 1'b0;
        w_load      = 1'b0;
        w_drain_acc = 1'b0;
        w_slot_free = !r_req_valid || req_ready;
        w_row_end   = (col >= r_col_max);
        w_pass_end  = w_row_end && (row >= r_row_max);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cfg_load  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_slot_free) begin
                    w_load = 1'b1;
                    if (w_pass_end) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (req_ready) begin
                    w_drain_acc = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter advances exactly when a beat is loaded, so nothing is dropped or repeated.
    assign inc = w_load;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_row_max   <= 10'd0;
            r_col_max   <= 10'd0;
            r_base      <= '0;
            r_stride    <= '0;
            r_row_base  <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_row   <= 10'd0;
            r_req_col   <= 10'd0;
            r_req_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_drain_acc;
            if (w_cfg_load) begin
                r_row_max  <= cfg_row_max;
                r_col_max  <= cfg_col_max;
                r_base     <= cfg_base;
                r_stride   <= cfg_stride;
                r_row_base <= cfg_base;
            end
            if (w_load) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= r_row_base + ADDR_W'(col);
                r_req_row   <= row;
                r_req_col   <= col;
                r_req_last  <= w_pass_end;
                // Row base steps by stride at each row end and rewinds at pass end.
                if (w_row_end) begin
                    r_row_base <= w_pass_end ? r_base : (r_row_base + r_stride);
                end
            end
            if (w_drain_acc) begin
                r_req_valid <= 1'b0;
            end
        end
    end

    assign row_max   = r_row_max;
    assign col_max   = r_col_max;
    assign req_valid = r_req_valid;
    assign req_addr  = r_req_addr;
    assign req_row   = r_req_row;
    assign req_col   = r_req_col;
    assign req_last  = r_req_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_matrix_fetch_seq.sv
// Bench for matrix_fetch_seq: table-driven passes plus random configs, a counter_2d model
// and a scoreboard of expected beats computed from base + row*stride + col.
module tb_matrix_fetch_seq;

    localparam int unsigned ADDR_W = 16;

    logic              CLK = 1'b0;
    logic              RST_L;
    logic              VDD;
    logic              GND;
    logic              start;
    logic [9:0]        cfg_row_max;
    logic [9:0]        cfg_col_max;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_stride;
    logic [9:0]        row_max;
    logic [9:0]        col_max;
    logic [9:0]        row;
    logic [9:0]        col;
    logic              inc;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [9:0]        req_row;
    logic [9:0]        req_col;
    logic              req_last;
    logic              busy;
    logic              done;

    matrix_fetch_seq #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST_L(RST_L), .VDD(VDD), .GND(GND), .start(start),
        .cfg_row_max(cfg_row_max), .cfg_col_max(cfg_col_max),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .row_max(row_max), .col_max(col_max), .row(row), .col(col), .inc(inc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_row(req_row), .req_col(req_col), .req_last(req_last),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          rows;
        int          cols;
        logic [15:0] base;
        logic [15:0] stride;
        int          mode;
        int          exp_beats;
        logic [15:0] exp_last_addr;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          loads_left = 0;
    int          n_acc    = 0;
    logic [15:0] last_addr = '0;
    logic        mon_stall = 1'b0;
    logic        mon_last_acc = 1'b0;
    beat_t       mon_prev;
    beat_t       mon_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected beats in row-major order from the closed-form address.
    task automatic build(input int rows, input int cols, input logic [15:0] base, input logic [15:0] stride);
        beat_t b;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                b.addr = 16'(int'(base) + r * int'(stride) + c);
                b.row  = 10'(r);
                b.col  = 10'(c);
                b.last = (r == rows - 1) && (c == cols - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // counter_2d behaviour.
    always @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            row <= 10'd0;
            col <= 10'd0;
        end else if (inc) begin
            if (col >= col_max) begin
                col <= 10'd0;
                row <= (row >= row_max) ? 10'd0 : 10'(row + 10'd1);
            end else begin
                col <= 10'(col + 10'd1);
            end
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!RST_L) begin
            mon_stall    = 1'b0;
            mon_last_acc = 1'b0;
        end else begin
            check("done", done, mon_last_acc);
            check("inc", inc, (loads_left > 0) && busy && (!req_valid || req_ready));
            if (inc) loads_left--;
            if (mon_stall) check("hold", {req_valid, req_addr, req_row, req_col, req_last}, {1'b1, mon_prev});
            mon_last_acc = 1'b0;
            if (req_valid && req_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    fail_now("extra_beat");
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat", {req_addr, req_row, req_col, req_last}, mon_b);
                end
                mon_last_acc = req_last;
                last_addr    = req_addr;
            end
            mon_stall = req_valid && !req_ready;
            mon_prev  = {req_addr, req_row, req_col, req_last};
        end
    end

    task automatic launch(input int rows, input int cols, input logic [15:0] base,
                          input logic [15:0] stride, output int c0);
        build(rows, cols, base, stride);
        loads_left  = rows * cols;
        n_acc       = 0;
        cfg_row_max = 10'(rows - 1);
        cfg_col_max = 10'(cols - 1);
        cfg_base    = base;
        cfg_stride  = stride;
        start       = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        c0    = cyc;
    endtask

    // Drives ready by mode until done is high; noise_at pulses a bogus start mid-pass.
    task automatic wait_done(input int mode, input int noise_at, input int c0, output int cycles);
        bit seen = 0;
        cycles = -1;
        for (int i = 1; i <= 500; i++) begin
            case (mode)
                0:       req_ready = 1'b1;
                1:       req_ready = (i % 2) == 1;
                default: req_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (i == noise_at) begin
                start       = 1'b1;
                cfg_row_max = 10'd5;
                cfg_col_max = 10'd5;
                cfg_base    = 16'h9000;
                cfg_stride  = 16'h0777;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            if (done) begin
                seen   = 1;
                cycles = cyc - c0;
                break;
            end
        end
        start = 1'b0;
        if (!seen) fail_now("done_timeout");
    endtask

    task automatic post_check(input string name, input int beats, input logic [15:0] last_a);
        check({name, "_beats"}, 64'(n_acc), 64'(beats));
        check({name, "_last_addr"}, last_addr, last_a);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, {busy, req_valid, row, col}, 22'd0);
    endtask

    initial begin
        vec_t tbl[6];
        int   c0;
        int   cycles;
        int   rr;
        int   cc;
        logic [15:0] bb;
        logic [15:0] ss;

        tbl[0] = '{2, 3, 16'h0100, 16'h0010, 0, 6, 16'h0112};
        tbl[1] = '{2, 3, 16'h0100, 16'h0010, 1, 6, 16'h0112};
        tbl[2] = '{1, 1, 16'hFFFF, 16'h0000, 0, 1, 16'hFFFF};
        tbl[3] = '{3, 2, 16'hFFF0, 16'h0008, 0, 6, 16'h0001};
        tbl[4] = '{4, 5, 16'h1234, 16'h0100, 2, 20, 16'h1538};
        tbl[5] = '{2, 2, 16'hFFFE, 16'hFFFF, 1, 4, 16'hFFFE};

        RST_L = 1'b0; VDD = 1'b1; GND = 1'b0; start = 1'b0; req_ready = 1'b0;
        cfg_row_max = '0; cfg_col_max = '0; cfg_base = '0; cfg_stride = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", {req_valid, busy, done, inc, req_last, row_max, col_max, req_addr},
              '0);
        RST_L = 1'b1;
        @(posedge CLK); #1;

        for (int t = 0; t < 6; t++) begin
            launch(tbl[t].rows, tbl[t].cols, tbl[t].base, tbl[t].stride, c0);
            wait_done(tbl[t].mode, 0, c0, cycles);
            post_check($sformatf("vec%0d", t), tbl[t].exp_beats, tbl[t].exp_last_addr);
            if (tbl[t].mode == 0) check($sformatf("vec%0d_latency", t), 64'(cycles), 64'(tbl[t].exp_beats + 1));
        end

        for (int k = 0; k < 6; k++) begin
            rr = $urandom_range(1, 4);
            cc = $urandom_range(1, 5);
            bb = 16'($urandom);
            ss = 16'($urandom);
            launch(rr, cc, bb, ss, c0);
            wait_done(2, 0, c0, cycles);
            post_check($sformatf("rnd%0d", k), rr * cc, 16'(int'(bb) + (rr - 1) * int'(ss) + cc - 1));
        end

        // Reset mid-pass after three accepts, then a clean replay from base.
        launch(4, 4, 16'h0200, 16'h0020, c0);
        req_ready = 1'b1;
        for (int i = 0; i < 50 && n_acc < 3; i++) begin
            @(posedge CLK); #1;
        end
        RST_L = 1'b0;
        #1;
        check("rst_mid", {req_valid, busy, inc, done}, 4'd0);
        exp_q.delete();
        loads_left = 0;
        @(posedge CLK); #1;
        RST_L = 1'b1;
        launch(2, 3, 16'h0100, 16'h0010, c0);
        wait_done(0, 0, c0, cycles);
        post_check("replay", 6, 16'h0112);
        check("replay_latency", 64'(cycles), 64'd7);

        // Start while busy is ignored; next start on the done cycle begins a fresh pass.
        launch(3, 2, 16'h0400, 16'h0040, c0);
        wait_done(0, 2, c0, cycles);
        post_check("noise", 6, 16'h0481);
        check("noise_cfg", {row_max, col_max}, {10'd2, 10'd1});
        launch(2, 2, 16'h0050, 16'h0003, c0);
        wait_done(0, 0, c0, cycles);
        post_check("b2b", 4, 16'h0054);
        check("b2b_latency", 64'(cycles), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
